// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
// Holds the FSM state encoding and the counter-width helper.
package piso_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    // Bit count width for a WIDTH-bit word; WIDTH is at least 2, so the result is at least 1.
    function automatic int clog2_w(input int w);
        int r;
        r = 0;
        while ((1 << r) < w) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/piso_shift_tx_if.sv
// Load handshake and serial output bundle for piso_shift_tx.
// The master drives the word and the step control. The slave is the transmitter.
interface piso_shift_tx_if #(
    parameter int WIDTH = 4
);

    logic [WIDTH-1:0] B;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             sout;
    logic             sout_valid;
    logic             done;

    modport master (
        output B, load_valid, shift_en,
        input  load_ready, sout, sout_valid, done
    );

    modport slave (
        input  B, load_valid, shift_en,
        output load_ready, sout, sout_valid, done
    );

endinterface

// File: rtl/piso_shift_tx_ffd_ar.sv
// Single-bit D flip-flop with asynchronous active-high reset.
// It is the storage cell of the transmitter shift chain.
module ffd_ar (
    input  logic D,
    input  logic clk,
    input  logic rst,
    output logic Q
);

    // Capture D on each rising edge; reset clears the bit immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q <= 1'b0;
        end else begin
            Q <= D;
        end
    end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter.
// It accepts a word through a valid/ready handshake and shifts it out one bit per
// enabled clock. The next word may be accepted on the last-bit cycle, so words can
// follow each other with no gap.
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic           sclk,
    input  logic           rst,
    piso_shift_tx_if.slave bus
);

    localparam int CW = clog2_w(WIDTH);

    logic             state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] neighbour;
    logic [WIDTH-1:0] d_in;
    logic             in_shift;
    logic             step;
    logic             last_bit;
    logic             accept;

    assign in_shift = (state == ST_SHIFT);
    assign step     = in_shift & bus.shift_en;
    assign last_bit = step & (cnt == CW'(WIDTH - 1));
    assign accept   = bus.load_valid & bus.load_ready;

    assign bus.load_ready = (state == ST_IDLE) | last_bit;
    assign bus.done       = last_bit;
    assign bus.sout_valid = in_shift;
    assign bus.sout       = in_shift & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);

    // Shift chain: each cell loads B on accept, takes its neighbour on a step, else holds.
    // The cell farthest from the output end fills with zero.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_chain
            if (MSB_FIRST) begin : g_toward_msb
                if (i == 0) begin : g_fill
                    assign neighbour[i] = 1'b0;
                end else begin : g_link
                    assign neighbour[i] = shreg[i-1];
                end
            end else begin : g_toward_lsb
                if (i == WIDTH - 1) begin : g_fill
                    assign neighbour[i] = 1'b0;
                end else begin : g_link
                    assign neighbour[i] = shreg[i+1];
                end
            end

            assign d_in[i] = accept ? bus.B[i] : (step ? neighbour[i] : shreg[i]);

            ffd_ar u_cell (
                .D   (d_in[i]),
                .clk (sclk),
                .rst (rst),
                .Q   (shreg[i])
            );
        end
    endgenerate

    // State and bit count: start a word on accept and count enabled steps.
    // The last step either chains the next word or returns to idle.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (state == ST_IDLE) begin
            if (accept) begin
                state <= ST_SHIFT;
                cnt   <= '0;
            end
        end else if (last_bit) begin
            cnt   <= '0;
            state <= accept ? ST_SHIFT : ST_IDLE;
        end else if (step) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed testbench for piso_shift_tx.
// It drives an LSB-first instance and an MSB-first instance with hand-computed vectors.
module tb_piso_shift_tx;

    logic sclk;
    logic rst;
    int   pass_count;
    int   check_count;

    piso_shift_tx_if #(.WIDTH(4)) if_lsb ();
    piso_shift_tx_if #(.WIDTH(4)) if_msb ();

    piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .sclk (sclk),
        .rst  (rst),
        .bus  (if_lsb.slave)
    );

    piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .sclk (sclk),
        .rst  (rst),
        .bus  (if_msb.slave)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    // Move to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic test_reset();
        if_lsb.B = 4'b0; if_lsb.load_valid = 1'b0; if_lsb.shift_en = 1'b1;
        if_msb.B = 4'b0; if_msb.load_valid = 1'b0; if_msb.shift_en = 1'b1;
        rst = 1'b1;
        #12;
        check_count++;
        if ({if_lsb.load_ready, if_lsb.sout, if_lsb.sout_valid, if_lsb.done} !== 4'b1000) begin
            $display("[TB] FAIL reset_outputs: got {ready,sout,valid,done}=%b want 1000",
                {if_lsb.load_ready, if_lsb.sout, if_lsb.sout_valid, if_lsb.done});
        end else pass_count++;
        rst = 1'b0;
        tick();
        tick();
    endtask

    // Word 1011 is sent LSB first, so the bits are 1,1,0,1. Done fires on cycle 4 only.
    task automatic test_lsb_basic();
        logic [3:0] exp_sout;
        logic [3:0] exp_done;
        exp_sout = 4'b1011;
        exp_done = 4'b1000;
        if_lsb.B = 4'b1011; if_lsb.load_valid = 1'b1; if_lsb.shift_en = 1'b1;
        @(negedge sclk);
        check_count++;
        if (if_lsb.load_ready !== 1'b1 || if_lsb.sout_valid !== 1'b0) begin
            $display("[TB] FAIL basic_idle: ready=%b valid=%b want 1 0", if_lsb.load_ready, if_lsb.sout_valid);
        end else pass_count++;
        tick();
        if_lsb.load_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge sclk);
            check_count++;
            if (if_lsb.sout !== exp_sout[k] || if_lsb.sout_valid !== 1'b1 || if_lsb.done !== exp_done[k]) begin
                $display("[TB] FAIL basic_bit%0d: sout=%b valid=%b done=%b want %b 1 %b",
                    k, if_lsb.sout, if_lsb.sout_valid, if_lsb.done, exp_sout[k], exp_done[k]);
            end else pass_count++;
            tick();
        end
        @(negedge sclk);
        check_count++;
        if (if_lsb.sout_valid !== 1'b0 || if_lsb.done !== 1'b0 || if_lsb.load_ready !== 1'b1) begin
            $display("[TB] FAIL basic_end_idle: valid=%b done=%b ready=%b want 0 0 1",
                if_lsb.sout_valid, if_lsb.done, if_lsb.load_ready);
        end else pass_count++;
        tick();
    endtask

    // Word 1000 is sent MSB first, so the bits are 1,0,0,0. Ready is 0 on cycles 1-3 and 1 on cycle 4.
    task automatic test_msb_first();
        logic [3:0] exp_sout;
        logic [3:0] exp_ready;
        exp_sout  = 4'b0001;
        exp_ready = 4'b1000;
        if_msb.B = 4'b1000; if_msb.load_valid = 1'b1; if_msb.shift_en = 1'b1;
        tick();
        if_msb.load_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge sclk);
            check_count++;
            if (if_msb.sout !== exp_sout[k] || if_msb.load_ready !== exp_ready[k] || if_msb.done !== exp_ready[k]) begin
                $display("[TB] FAIL msb_bit%0d: sout=%b ready=%b done=%b want %b %b %b",
                    k, if_msb.sout, if_msb.load_ready, if_msb.done, exp_sout[k], exp_ready[k], exp_ready[k]);
            end else pass_count++;
            tick();
        end
        @(negedge sclk);
        check_count++;
        if (if_msb.sout_valid !== 1'b0) begin
            $display("[TB] FAIL msb_end_idle: valid=%b want 0", if_msb.sout_valid);
        end else pass_count++;
        tick();
    endtask

    // Word 0110 with shift_en low for 3 cycles starting at cycle 2. Bit 1 holds and done moves to cycle 7.
    task automatic test_stall();
        logic [6:0] en;
        logic [6:0] exp_sout;
        logic [6:0] exp_done;
        en       = 7'b1110001;
        exp_sout = 7'b0111110;
        exp_done = 7'b1000000;
        if_lsb.B = 4'b0110; if_lsb.load_valid = 1'b1; if_lsb.shift_en = 1'b1;
        tick();
        if_lsb.load_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if_lsb.shift_en = en[k];
            @(negedge sclk);
            check_count++;
            if (if_lsb.sout !== exp_sout[k] || if_lsb.sout_valid !== 1'b1 || if_lsb.done !== exp_done[k]) begin
                $display("[TB] FAIL stall_cycle%0d: sout=%b valid=%b done=%b want %b 1 %b",
                    k + 1, if_lsb.sout, if_lsb.sout_valid, if_lsb.done, exp_sout[k], exp_done[k]);
            end else pass_count++;
            tick();
        end
        if_lsb.shift_en = 1'b1;
        @(negedge sclk);
        check_count++;
        if (if_lsb.sout_valid !== 1'b0) begin
            $display("[TB] FAIL stall_end_idle: valid=%b want 0", if_lsb.sout_valid);
        end else pass_count++;
        tick();
    endtask

    // Words 1111 then 0000 with load_valid held high. This gives 8 contiguous bits and done on cycles 4 and 8.
    task automatic test_back_to_back();
        logic [7:0] exp_sout;
        logic [7:0] exp_done;
        exp_sout = 8'b00001111;
        exp_done = 8'b10001000;
        if_lsb.B = 4'b1111; if_lsb.load_valid = 1'b1; if_lsb.shift_en = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k == 3) if_lsb.B = 4'b0000;
            if (k == 4) if_lsb.load_valid = 1'b0;
            @(negedge sclk);
            check_count++;
            if (if_lsb.sout !== exp_sout[k] || if_lsb.sout_valid !== 1'b1 || if_lsb.done !== exp_done[k]) begin
                $display("[TB] FAIL b2b_cycle%0d: sout=%b valid=%b done=%b want %b 1 %b",
                    k + 1, if_lsb.sout, if_lsb.sout_valid, if_lsb.done, exp_sout[k], exp_done[k]);
            end else pass_count++;
            tick();
        end
        @(negedge sclk);
        check_count++;
        if (if_lsb.sout_valid !== 1'b0) begin
            $display("[TB] FAIL b2b_end_idle: valid=%b want 0", if_lsb.sout_valid);
        end else pass_count++;
        tick();
    endtask

    // Reset is applied mid-word after 2 bits, and the outputs clear at once.
    // Word 0100 is then sent from bit 0 as 0,0,1,0.
    task automatic test_reset_abort();
        logic [3:0] exp_sout;
        if_lsb.B = 4'b1011; if_lsb.load_valid = 1'b1; if_lsb.shift_en = 1'b1;
        tick();
        if_lsb.load_valid = 1'b0;
        tick();
        tick();
        #1;
        rst = 1'b1;
        #1;
        check_count++;
        if ({if_lsb.load_ready, if_lsb.sout, if_lsb.sout_valid, if_lsb.done} !== 4'b1000) begin
            $display("[TB] FAIL abort_async: got {ready,sout,valid,done}=%b want 1000",
                {if_lsb.load_ready, if_lsb.sout, if_lsb.sout_valid, if_lsb.done});
        end else pass_count++;
        #1;
        rst = 1'b0;
        tick();
        exp_sout = 4'b0100;
        if_lsb.B = 4'b0100; if_lsb.load_valid = 1'b1;
        tick();
        if_lsb.load_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge sclk);
            check_count++;
            if (if_lsb.sout !== exp_sout[k] || if_lsb.done !== (k == 3)) begin
                $display("[TB] FAIL abort_next_bit%0d: sout=%b done=%b want %b %b",
                    k, if_lsb.sout, if_lsb.done, exp_sout[k], (k == 3));
            end else pass_count++;
            tick();
        end
    endtask

    // Load_valid is pulsed while bits 1-3 shift and B toggles. Word 1001 must still send as 1,0,0,1.
    task automatic test_ignore_load();
        logic [3:0] exp_sout;
        exp_sout = 4'b1001;
        if_lsb.B = 4'b1001; if_lsb.load_valid = 1'b1; if_lsb.shift_en = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                if_lsb.load_valid = 1'b1;
                if_lsb.B = ~if_lsb.B;
            end else begin
                if_lsb.load_valid = 1'b0;
                if_lsb.B = 4'($urandom);
            end
            @(negedge sclk);
            check_count++;
            if (if_lsb.sout !== exp_sout[k] || if_lsb.load_ready !== (k == 3)) begin
                $display("[TB] FAIL ignore_bit%0d: sout=%b ready=%b want %b %b",
                    k, if_lsb.sout, if_lsb.load_ready, exp_sout[k], (k == 3));
            end else pass_count++;
            tick();
        end
        @(negedge sclk);
        check_count++;
        if (if_lsb.sout_valid !== 1'b0) begin
            $display("[TB] FAIL ignore_end_idle: valid=%b want 0", if_lsb.sout_valid);
        end else pass_count++;
        tick();
    endtask

    // Run the scenarios in order, then print the summary line.
    initial begin
        pass_count  = 0;
        check_count = 0;
        test_reset();
        test_lsb_basic();
        test_msb_first();
        test_stall();
        test_back_to_back();
        test_reset_abort();
        test_ignore_load();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
